// File: rtl/lsp.sv
// Load/store pipe: effective-address generation, one blocking data-memory transaction per op, load writeback.
// Optional LSP_MISALIGN_TRAP_EN: misaligned ops skip memory and report lsp_wb_exc instead of being aligned down.
module lsp #(
    parameter int unsigned AW = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [63:0]   ix_lsp_pc,
    input  logic [4:0]    ix_lsp_dst,
    input  logic          ix_lsp_wb_en,
    input  logic [63:0]   ix_lsp_base,
    input  logic [11:0]   ix_lsp_offset,
    input  logic [63:0]   ix_lsp_source,
    input  logic          ix_lsp_mem_sign,
    input  logic [1:0]    ix_lsp_mem_width,
    input  logic          ix_lsp_valid,
    output logic          ix_lsp_ready,
    output logic          lsp_ix_mem_busy,
    output logic          lsp_ix_mem_wb_en,
    output logic [4:0]    lsp_ix_mem_dst,
    output logic [AW-1:0] dm_req_addr,
    output logic          dm_req_wen,
    output logic [63:0]   dm_req_wdata,
    output logic [7:0]    dm_req_wmask,
    output logic          dm_req_valid,
    input  logic          dm_req_ready,
    input  logic [63:0]   dm_resp_rdata,
    input  logic          dm_resp_valid,
    output logic [63:0]   lsp_wb_pc,
    output logic [4:0]    lsp_wb_dst,
    output logic [63:0]   lsp_wb_result,
    output logic          lsp_wb_wb_en,
    output logic          lsp_wb_valid,
    output logic          lsp_wb_exc
);
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_e;

`ifdef LSP_MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    state_e      state_q, state_d;
    logic [63:0] pc_q, pc_d;
    logic [4:0]  dst_q, dst_d;
    logic        wb_en_q, wb_en_d;
    logic        sign_q, sign_d;
    logic [1:0]  width_q, width_d;
    logic [63:0] addr_q, addr_d;
    logic [63:0] wdata_q, wdata_d;
    logic [7:0]  wmask_q, wmask_d;
    logic [63:0] wb_pc_q, wb_pc_d;
    logic [4:0]  wb_dst_q, wb_dst_d;
    logic [63:0] wb_result_q, wb_result_d;
    logic        wb_wb_en_q, wb_wb_en_d;
    logic        wb_valid_q, wb_valid_d;
    logic        wb_exc_q, wb_exc_d;

    logic [63:0] eff, eff_al, src_rep, rd_shift, ld_data;
    logic [2:0]  size_m1;
    logic [7:0]  mask_base;
    logic        misalign;

    // Issue-side decode: effective address, alignment, replicated store data, lane mask.
    always_comb begin : issue_decode
        eff = ix_lsp_base + {{52{ix_lsp_offset[11]}}, ix_lsp_offset};
        case (ix_lsp_mem_width)
            2'd0: begin size_m1 = 3'd0; mask_base = 8'h01; src_rep = {8{ix_lsp_source[7:0]}};  end
            2'd1: begin size_m1 = 3'd1; mask_base = 8'h03; src_rep = {4{ix_lsp_source[15:0]}}; end
            2'd2: begin size_m1 = 3'd3; mask_base = 8'h0F; src_rep = {2{ix_lsp_source[31:0]}}; end
            default: begin size_m1 = 3'd7; mask_base = 8'hFF; src_rep = ix_lsp_source;       end
        endcase
        misalign = |(eff[2:0] & size_m1);
        eff_al   = {eff[63:3], eff[2:0] & ~size_m1};
    end

    // Response-side lane extraction and sign/zero extension; D ignores the sign flag.
    always_comb begin : load_align
        rd_shift = dm_resp_rdata >> {addr_q[2:0], 3'b000};
        case (width_q)
            2'd0:    ld_data = {{56{sign_q & rd_shift[7]}},  rd_shift[7:0]};
            2'd1:    ld_data = {{48{sign_q & rd_shift[15]}}, rd_shift[15:0]};
            2'd2:    ld_data = {{32{sign_q & rd_shift[31]}}, rd_shift[31:0]};
            default: ld_data = rd_shift;
        endcase
    end

    always_comb begin : next_state
        state_d     = state_q;
        pc_d        = pc_q;
        dst_d       = dst_q;
        wb_en_d     = wb_en_q;
        sign_d      = sign_q;
        width_d     = width_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wmask_d     = wmask_q;
        wb_pc_d     = wb_pc_q;
        wb_dst_d    = wb_dst_q;
        wb_result_d = wb_result_q;
        wb_wb_en_d  = wb_wb_en_q;
        wb_valid_d  = 1'b0;
        wb_exc_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (ix_lsp_valid) begin
                    pc_d    = ix_lsp_pc;
                    dst_d   = ix_lsp_dst;
                    wb_en_d = ix_lsp_wb_en;
                    sign_d  = ix_lsp_mem_sign;
                    width_d = ix_lsp_mem_width;
                    addr_d  = eff_al;
                    wdata_d = src_rep;
                    wmask_d = mask_base << eff_al[2:0];
                    if (TRAP_EN && misalign) begin
                        wb_valid_d  = 1'b1;
                        wb_exc_d    = 1'b1;
                        wb_wb_en_d  = 1'b0;
                        wb_result_d = eff;
                        wb_pc_d     = ix_lsp_pc;
                        wb_dst_d    = ix_lsp_dst;
                    end else begin
                        state_d = S_REQ;
                    end
                end
            end
            S_REQ: begin
                if (dm_req_ready) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (dm_resp_valid) begin
                    state_d     = S_IDLE;
                    wb_valid_d  = 1'b1;
                    wb_pc_d     = pc_q;
                    wb_dst_d    = dst_q;
                    wb_wb_en_d  = wb_en_q;
                    wb_result_d = wb_en_q ? ld_data : 64'd0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            pc_q        <= 64'd0;
            dst_q       <= 5'd0;
            wb_en_q     <= 1'b0;
            sign_q      <= 1'b0;
            width_q     <= 2'd0;
            addr_q      <= 64'd0;
            wdata_q     <= 64'd0;
            wmask_q     <= 8'd0;
            wb_pc_q     <= 64'd0;
            wb_dst_q    <= 5'd0;
            wb_result_q <= 64'd0;
            wb_wb_en_q  <= 1'b0;
            wb_valid_q  <= 1'b0;
            wb_exc_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            dst_q       <= dst_d;
            wb_en_q     <= wb_en_d;
            sign_q      <= sign_d;
            width_q     <= width_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wmask_q     <= wmask_d;
            wb_pc_q     <= wb_pc_d;
            wb_dst_q    <= wb_dst_d;
            wb_result_q <= wb_result_d;
            wb_wb_en_q  <= wb_wb_en_d;
            wb_valid_q  <= wb_valid_d;
            wb_exc_q    <= wb_exc_d;
        end
    end

    // Hazard info and request fields decode directly from the state and latched op.
    assign ix_lsp_ready     = (state_q == S_IDLE);
    assign lsp_ix_mem_busy  = (state_q != S_IDLE);
    assign lsp_ix_mem_wb_en = lsp_ix_mem_busy & wb_en_q;
    assign lsp_ix_mem_dst   = dst_q;
    assign dm_req_valid     = (state_q == S_REQ);
    assign dm_req_addr      = addr_q[AW-1:0];
    assign dm_req_wen       = ~wb_en_q;
    assign dm_req_wdata     = wdata_q;
    assign dm_req_wmask     = wmask_q;
    assign lsp_wb_pc        = wb_pc_q;
    assign lsp_wb_dst       = wb_dst_q;
    assign lsp_wb_result    = wb_result_q;
    assign lsp_wb_wb_en     = wb_wb_en_q;
    assign lsp_wb_valid     = wb_valid_q;
    assign lsp_wb_exc       = wb_exc_q;
endmodule

// File: tb/tb_lsp.sv
// Scoreboard bench for lsp: issue driver pushes expected requests/writebacks, memory responder and writeback monitor check them.
`timescale 1ns/1ps
module tb_lsp;
    localparam int unsigned AW = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic [63:0]   ix_lsp_pc, ix_lsp_base, ix_lsp_source;
    logic [4:0]    ix_lsp_dst;
    logic          ix_lsp_wb_en, ix_lsp_mem_sign, ix_lsp_valid;
    logic [11:0]   ix_lsp_offset;
    logic [1:0]    ix_lsp_mem_width;
    logic          ix_lsp_ready, lsp_ix_mem_busy, lsp_ix_mem_wb_en;
    logic [4:0]    lsp_ix_mem_dst;
    logic [AW-1:0] dm_req_addr;
    logic          dm_req_wen, dm_req_valid, dm_req_ready;
    logic [63:0]   dm_req_wdata;
    logic [7:0]    dm_req_wmask;
    logic [63:0]   dm_resp_rdata;
    logic          dm_resp_valid;
    logic [63:0]   lsp_wb_pc, lsp_wb_result;
    logic [4:0]    lsp_wb_dst;
    logic          lsp_wb_wb_en, lsp_wb_valid, lsp_wb_exc;

    lsp #(.AW(AW)) dut (
        .clk(clk), .rst(rst),
        .ix_lsp_pc(ix_lsp_pc), .ix_lsp_dst(ix_lsp_dst), .ix_lsp_wb_en(ix_lsp_wb_en),
        .ix_lsp_base(ix_lsp_base), .ix_lsp_offset(ix_lsp_offset), .ix_lsp_source(ix_lsp_source),
        .ix_lsp_mem_sign(ix_lsp_mem_sign), .ix_lsp_mem_width(ix_lsp_mem_width),
        .ix_lsp_valid(ix_lsp_valid), .ix_lsp_ready(ix_lsp_ready),
        .lsp_ix_mem_busy(lsp_ix_mem_busy), .lsp_ix_mem_wb_en(lsp_ix_mem_wb_en),
        .lsp_ix_mem_dst(lsp_ix_mem_dst),
        .dm_req_addr(dm_req_addr), .dm_req_wen(dm_req_wen), .dm_req_wdata(dm_req_wdata),
        .dm_req_wmask(dm_req_wmask), .dm_req_valid(dm_req_valid), .dm_req_ready(dm_req_ready),
        .dm_resp_rdata(dm_resp_rdata), .dm_resp_valid(dm_resp_valid),
        .lsp_wb_pc(lsp_wb_pc), .lsp_wb_dst(lsp_wb_dst), .lsp_wb_result(lsp_wb_result),
        .lsp_wb_wb_en(lsp_wb_wb_en), .lsp_wb_valid(lsp_wb_valid), .lsp_wb_exc(lsp_wb_exc)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] addr;
        logic        wen;
        logic [63:0] wdata;
        logic [7:0]  wmask;
    } req_t;

    typedef struct packed {
        logic [63:0] pc;
        logic [4:0]  dst;
        logic [63:0] result;
        logic        wb_en;
        logic        exc;
    } wb_t;

    req_t        req_q[$];
    wb_t         wb_q[$];
    logic [63:0] rdata_q[$];

    int checks   = 0;
    int failures = 0;
    int hold_n   = 0;
    bit stray_go = 1'b0;

    task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one op when the pipe is ready; the reference model fills the scoreboard queues.
    task automatic issue(input logic [63:0] pc, input logic [4:0] dst, input logic wb_en,
                         input logic [63:0] base, input logic [11:0] off, input logic [63:0] src,
                         input logic sign, input logic [1:0] w, input logic [63:0] rdata);
        int n;
        int size, lane;
        logic signed [63:0] so;
        logic [63:0] eff, al, wd, v;
        logic [7:0] wm;
        bit trap;
        req_t r;
        wb_t  e;
        n = 0;
        while (!ix_lsp_ready) begin
            if (n >= 200) begin
                chk(1'b0, "issue_timeout", 64'(ix_lsp_ready), 64'd1);
                ix_lsp_valid = 1'b0;
                return;
            end
            ix_lsp_valid  = 1'($urandom);
            ix_lsp_base   = {$urandom, $urandom};
            ix_lsp_offset = 12'($urandom);
            @(negedge clk);
            n++;
        end
        ix_lsp_pc = pc; ix_lsp_dst = dst; ix_lsp_wb_en = wb_en; ix_lsp_base = base;
        ix_lsp_offset = off; ix_lsp_source = src; ix_lsp_mem_sign = sign;
        ix_lsp_mem_width = w; ix_lsp_valid = 1'b1;

        so   = $signed(off);
        eff  = base + so;
        size = 1 << w;
        al   = eff - (eff % 64'(size));
        lane = int'(al % 64'd8);
        trap = 1'b0;
`ifdef LSP_MISALIGN_TRAP_EN
        trap = (al != eff);
`endif
        if (trap) begin
            e = '{pc, dst, eff, 1'b0, 1'b1};
            wb_q.push_back(e);
        end else begin
            wd = '0; wm = '0; v = '0;
            for (int i = 0; i < 8; i++) begin
                wd[8*i +: 8] = src[8*(i % size) +: 8];
                wm[i] = (i >= lane) && (i < lane + size);
            end
            r = '{al, !wb_en, wd, wm};
            req_q.push_back(r);
            rdata_q.push_back(rdata);
            if (wb_en) begin
                for (int b = 0; b < size; b++) v[8*b +: 8] = rdata[8*(lane + b) +: 8];
                if (sign && size < 8 && v[8*size - 1])
                    for (int b = size; b < 8; b++) v[8*b +: 8] = 8'hFF;
            end
            e = '{pc, dst, v, wb_en, 1'b0};
            wb_q.push_back(e);
        end
        @(negedge clk);
        ix_lsp_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (wb_q.size() != 0 || !ix_lsp_ready) begin
            if (n >= 500) begin
                chk(1'b0, "drain_timeout", 64'(wb_q.size()), 64'd0);
                return;
            end
            @(negedge clk);
            n++;
        end
    endtask

    // Memory responder: random ready/latency, stray responses outside WAIT, request checks.
    initial begin : responder
        bit          outst;
        bit          prev_stall;
        int          dly;
        logic [63:0] cur_rdata;
        req_t        saved, e;
        outst = 1'b0; prev_stall = 1'b0; dly = 0; cur_rdata = '0; saved = '0;
        dm_req_ready = 1'b0; dm_resp_valid = 1'b0; dm_resp_rdata = '0;
        forever begin
            @(negedge clk);
            #1;
            dm_resp_valid = 1'b0;
            dm_req_ready  = 1'b0;
            if (rst) begin
                outst = 1'b0; prev_stall = 1'b0;
                continue;
            end
            if (outst) begin
                if (dly == 0) begin
                    dm_resp_valid = 1'b1;
                    dm_resp_rdata = cur_rdata;
                    outst = 1'b0;
                end else begin
                    dly--;
                end
            end else if (stray_go || ($urandom % 8) == 0) begin
                dm_resp_valid = 1'b1;
                dm_resp_rdata = {$urandom, $urandom};
                stray_go = 1'b0;
            end
            if (dm_req_valid) begin
                if (prev_stall) begin
                    chk(64'(dm_req_addr) == saved.addr, "req_addr_stable", 64'(dm_req_addr), saved.addr);
                    chk(dm_req_wdata == saved.wdata, "req_wdata_stable", dm_req_wdata, saved.wdata);
                    chk(dm_req_wmask == saved.wmask && dm_req_wen == saved.wen, "req_ctl_stable",
                        {dm_req_wen, dm_req_wmask}, {saved.wen, saved.wmask});
                end
                if (hold_n > 0) begin
                    hold_n--;
                    dm_req_ready = 1'b0;
                end else begin
                    dm_req_ready = (($urandom % 3) != 0);
                end
                if (dm_req_ready) begin
                    prev_stall = 1'b0;
                    if (req_q.size() == 0) begin
                        chk(1'b0, "req_unexpected", 64'(dm_req_addr), 64'd0);
                    end else begin
                        e = req_q.pop_front();
                        cur_rdata = rdata_q.pop_front();
                        chk(64'(dm_req_addr) == e.addr, "req_addr", 64'(dm_req_addr), e.addr);
                        chk(dm_req_wen == e.wen, "req_wen", 64'(dm_req_wen), 64'(e.wen));
                        chk(dm_req_wdata == e.wdata, "req_wdata", dm_req_wdata, e.wdata);
                        chk(dm_req_wmask == e.wmask, "req_wmask", 64'(dm_req_wmask), 64'(e.wmask));
                    end
                    outst = 1'b1;
                    dly = int'($urandom % 4);
                end else begin
                    prev_stall = 1'b1;
                    saved = '{64'(dm_req_addr), dm_req_wen, dm_req_wdata, dm_req_wmask};
                end
            end else begin
                prev_stall = 1'b0;
                dm_req_ready = 1'($urandom);
            end
        end
    end

    // Writeback monitor: every pulse must match the oldest expected writeback.
    initial begin : wb_monitor
        wb_t e;
        forever begin
            @(negedge clk);
            #2;
            if (!rst && lsp_wb_valid) begin
                if (wb_q.size() == 0) begin
                    chk(1'b0, "wb_unexpected", lsp_wb_result, 64'd0);
                end else begin
                    e = wb_q.pop_front();
                    chk(lsp_wb_pc == e.pc, "wb_pc", lsp_wb_pc, e.pc);
                    chk(lsp_wb_dst == e.dst, "wb_dst", 64'(lsp_wb_dst), 64'(e.dst));
                    chk(lsp_wb_result == e.result, "wb_result", lsp_wb_result, e.result);
                    chk(lsp_wb_wb_en == e.wb_en, "wb_en", 64'(lsp_wb_wb_en), 64'(e.wb_en));
                    chk(lsp_wb_exc == e.exc, "wb_exc", 64'(lsp_wb_exc), 64'(e.exc));
                end
            end
        end
    end

    initial begin : watchdog
        #2ms;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int n;
        rst = 1'b1;
        ix_lsp_pc = '0; ix_lsp_dst = '0; ix_lsp_wb_en = 1'b0; ix_lsp_base = '0;
        ix_lsp_offset = '0; ix_lsp_source = '0; ix_lsp_mem_sign = 1'b0;
        ix_lsp_mem_width = '0; ix_lsp_valid = 1'b0;
        #1;
        chk(ix_lsp_ready == 1'b1, "rst_ready", 64'(ix_lsp_ready), 64'd1);
        chk(dm_req_valid == 1'b0, "rst_req_valid", 64'(dm_req_valid), 64'd0);
        chk(lsp_wb_valid == 1'b0, "rst_wb_valid", 64'(lsp_wb_valid), 64'd0);
        chk(lsp_wb_exc == 1'b0, "rst_wb_exc", 64'(lsp_wb_exc), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Directed examples: LD D, LB signed/unsigned, SH negative offset, misaligned LW.
        issue(64'h100, 5'd1, 1'b1, 64'h1000, 12'd8, 64'h0, 1'b0, 2'd3, 64'h1122334455667788);
        issue(64'h104, 5'd2, 1'b1, 64'h2003, 12'd0, 64'h0, 1'b1, 2'd0, 64'h0000000080000000);
        issue(64'h108, 5'd3, 1'b1, 64'h2003, 12'd0, 64'h0, 1'b0, 2'd0, 64'h0000000080000000);
        issue(64'h10C, 5'd0, 1'b0, 64'h3000, 12'hFFE, 64'hABCD, 1'b0, 2'd1, 64'h0);
        issue(64'h110, 5'd4, 1'b1, 64'h1002, 12'd0, 64'h0, 1'b0, 2'd2, 64'hCAFEF00D12345678);
        drain();
        chk(lsp_ix_mem_wb_en == 1'b0, "idle_mem_wb_en", 64'(lsp_ix_mem_wb_en), 64'd0);
        chk(lsp_ix_mem_busy == 1'b0, "idle_mem_busy", 64'(lsp_ix_mem_busy), 64'd0);

        // Stalled request: hazard outputs reflect a latched load to x7.
        hold_n = 5;
        issue(64'h200, 5'd7, 1'b1, 64'h4000, 12'd0, 64'h0, 1'b0, 2'd3, 64'h5555AAAA5555AAAA);
        for (int i = 0; i < 5; i++) begin
            chk(dm_req_valid == 1'b1, "hold_req_valid", 64'(dm_req_valid), 64'd1);
            chk(ix_lsp_ready == 1'b0, "hold_ready", 64'(ix_lsp_ready), 64'd0);
            chk(lsp_ix_mem_busy == 1'b1, "hold_busy", 64'(lsp_ix_mem_busy), 64'd1);
            chk(lsp_ix_mem_wb_en == 1'b1, "hold_mem_wb_en", 64'(lsp_ix_mem_wb_en), 64'd1);
            chk(lsp_ix_mem_dst == 5'd7, "hold_mem_dst", 64'(lsp_ix_mem_dst), 64'd7);
            @(negedge clk);
        end
        drain();

        // Reset while waiting for the response, then a stray response must be ignored.
        issue(64'h300, 5'd9, 1'b1, 64'h5000, 12'd0, 64'h0, 1'b0, 2'd3, 64'h0123456789ABCDEF);
        n = 0;
        while (!(lsp_ix_mem_busy && !dm_req_valid) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk(lsp_ix_mem_busy && !dm_req_valid, "reach_wait", 64'(lsp_ix_mem_busy), 64'd1);
        rst = 1'b1;
        wb_q.delete(); req_q.delete(); rdata_q.delete();
        #1;
        chk(ix_lsp_ready == 1'b1, "midrst_ready", 64'(ix_lsp_ready), 64'd1);
        chk(lsp_ix_mem_busy == 1'b0, "midrst_busy", 64'(lsp_ix_mem_busy), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        stray_go = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk(lsp_wb_valid == 1'b0, "stray_no_wb", 64'(lsp_wb_valid), 64'd0);
            chk(ix_lsp_ready == 1'b1, "stray_ready", 64'(ix_lsp_ready), 64'd1);
        end

        // Randomized ops with idle gaps.
        for (int k = 0; k < 300; k++) begin
            issue({$urandom, $urandom}, 5'($urandom), 1'($urandom), {$urandom, $urandom},
                  12'($urandom), {$urandom, $urandom}, 1'($urandom), 2'($urandom),
                  {$urandom, $urandom});
            repeat ($urandom % 3) @(negedge clk);
        end
        drain();
        repeat (3) @(negedge clk);
        chk(wb_q.size() == 0 && req_q.size() == 0, "queues_empty", 64'(wb_q.size() + req_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
